// File: rtl/instr_encoder.sv
// instr_encoder: turns instruction descriptions into 16-bit program words with sequential addresses.
// Ports:
//   clk, reset_n           clock and asynchronous active-low reset
//   in_valid/in_ready      request handshake; in_op, in_imm_mode, in_rdest, in_rsrc, in_imm describe it
//   out_valid/out_ready    word handshake; out_word is the encoded word stored at out_addr
//   err                    one-cycle pulse after an unencodable request is accepted
module instr_encoder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic        in_imm_mode,
    input  logic [3:0]  in_rdest,
    input  logic [3:0]  in_rsrc,
    input  logic [15:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_word,
    output logic [7:0]  out_addr,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, EMIT_HI, EMIT_LAST} state_t;
    state_t      state_q;
    logic [15:0] word_q, lo_q;
    logic [7:0]  addr_q;
    logic        err_q;
    logic [3:0]  ext;
    logic        sext_ok, zext_ok, imm_ok, ok, two;
    logic [15:0] single, hi, lo;
    logic        accept, xfer;
    always_comb begin
        ext = 4'b0000;
        case (in_op)
            4'd0: ext = 4'b0101;
            4'd1: ext = 4'b1001;
            4'd2: ext = 4'b1110;
            4'd3: ext = 4'b0010;
            4'd4: ext = 4'b1011;
            4'd5: ext = 4'b0001;
            4'd6: ext = 4'b0011;
            4'd7: ext = 4'b1101;
            4'd8: ext = 4'b0100;
            4'd9: ext = 4'b0110;
            default: ext = 4'b0000;
        endcase
    end
    // Arithmetic immediates are sign-extended from 8 bits, logical ones zero-extended.
    assign sext_ok = (&in_imm[15:7]) | ~(|in_imm[15:7]);
    assign zext_ok = ~(|in_imm[15:8]);
    always_comb begin
        imm_ok = 1'b0;
        case (in_op)
            4'd0, 4'd1, 4'd2, 4'd4: imm_ok = sext_ok;
            4'd3, 4'd5, 4'd6:       imm_ok = zext_ok;
            4'd7:                   imm_ok = 1'b1;
            4'd8:                   imm_ok = ~(|in_imm[15:4]);
            default:                imm_ok = 1'b0;
        endcase
    end
    assign ok  = (in_op <= 4'd9) & (~in_imm_mode | imm_ok);
    // A wide MOV immediate splits into LUI (upper byte) followed by ORI (lower byte).
    assign two = in_imm_mode & (in_op == 4'd7) & ~zext_ok;
    assign hi  = {4'b1111, in_rdest, in_imm[15:8]};
    assign lo  = {4'b0010, in_rdest, in_imm[7:0]};
    assign single = !in_imm_mode ? {(in_op >= 4'd8) ? 4'b1000 : 4'b0000, in_rdest, ext, in_rsrc}
                  : (in_op == 4'd8) ? {4'b1000, in_rdest, 4'b0000, in_imm[3:0]}
                  : {ext, in_rdest, in_imm[7:0]};
    assign in_ready  = (state_q == IDLE) | ((state_q == EMIT_LAST) & out_ready);
    assign out_valid = (state_q != IDLE);
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;
    assign out_word  = word_q;
    assign out_addr  = addr_q;
    assign err       = err_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            word_q  <= 16'h0000;
            lo_q    <= 16'h0000;
            addr_q  <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (xfer) addr_q <= addr_q + 8'd1;
            if (state_q == EMIT_HI) begin
                if (out_ready) begin
                    state_q <= EMIT_LAST;
                    word_q  <= lo_q;
                end
            end else if (accept) begin
                if (!ok) begin
                    state_q <= IDLE;
                    err_q   <= 1'b1;
                end else if (two) begin
                    state_q <= EMIT_HI;
                    word_q  <= hi;
                    lo_q    <= lo;
                end else begin
                    state_q <= EMIT_LAST;
                    word_q  <= single;
                end
            end else if (state_q == EMIT_LAST && out_ready) begin
                state_q <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder.
// Ports: none (drives and observes every port of instr_encoder).
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        reset_n, in_valid, in_ready, in_imm_mode, out_valid, out_ready, err;
    logic [3:0]  in_op, in_rdest, in_rsrc;
    logic [15:0] in_imm, out_word;
    logic [7:0]  out_addr;
    int          checks = 0;
    int          errors = 0;

    instr_encoder dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_imm_mode(in_imm_mode), .in_rdest(in_rdest), .in_rsrc(in_rsrc),
        .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_addr(out_addr), .err(err)
    );

    always #5 clk = ~clk;

    // Present one request for one edge, then scramble the fields so later changes are visible if not captured.
    task automatic issue(input logic [3:0] op, input logic m, input logic [3:0] rd, input logic [3:0] rs, input logic [15:0] imm);
        in_op = op; in_imm_mode = m; in_rdest = rd; in_rsrc = rs; in_imm = imm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_rdest = ~rd; in_rsrc = ~rs; in_imm = ~imm; in_op = ~op;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 4'd0; in_imm_mode = 1'b0; in_rdest = 4'd0; in_rsrc = 4'd0; in_imm = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_word !== 16'h0000) begin errors++; $display("FAIL reset_word got %h want 0000", out_word); end
        checks++; if (out_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", out_addr); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
        reset_n = 1'b1;
        idle();
    endtask

    task automatic test_reg_add();
        issue(4'd0, 1'b0, 4'd3, 4'd5, 16'h0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_reg_valid got %b want 1", out_valid); end
        checks++; if (out_word !== 16'h0355) begin errors++; $display("FAIL add_reg_word got %h want 0355", out_word); end
        checks++; if (out_addr !== 8'h00) begin errors++; $display("FAIL add_reg_addr got %h want 00", out_addr); end
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_reg_done got %b want 0", out_valid); end
        checks++; if (out_addr !== 8'h01) begin errors++; $display("FAIL add_reg_addr_inc got %h want 01", out_addr); end
    endtask

    task automatic test_imm_alu();
        issue(4'd0, 1'b1, 4'd2, 4'd0, 16'hFFFD);
        checks++; if (out_word !== 16'h52FD || out_addr !== 8'h01) begin errors++; $display("FAIL addi got %h@%h want 52fd@01", out_word, out_addr); end
        idle();
        issue(4'd1, 1'b1, 4'd0, 4'd0, 16'h0005);
        checks++; if (out_word !== 16'h9005 || out_addr !== 8'h02) begin errors++; $display("FAIL subi got %h@%h want 9005@02", out_word, out_addr); end
        idle();
        issue(4'd8, 1'b1, 4'd7, 4'd0, 16'h0003);
        checks++; if (out_word !== 16'h8703 || out_addr !== 8'h03) begin errors++; $display("FAIL lshi got %h@%h want 8703@03", out_word, out_addr); end
        idle();
        issue(4'd3, 1'b1, 4'd1, 4'd0, 16'h00FF);
        checks++; if (out_word !== 16'h21FF || out_addr !== 8'h04) begin errors++; $display("FAIL ori got %h@%h want 21ff@04", out_word, out_addr); end
        idle();
    endtask

    task automatic test_mov();
        issue(4'd7, 1'b1, 4'd4, 4'd0, 16'h12AB);
        checks++; if (out_word !== 16'hF412 || out_addr !== 8'h05) begin errors++; $display("FAIL mov_lui got %h@%h want f412@05", out_word, out_addr); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mov_hi_ready got %b want 0", in_ready); end
        idle();
        checks++; if (out_word !== 16'h24AB || out_addr !== 8'h06) begin errors++; $display("FAIL mov_ori got %h@%h want 24ab@06", out_word, out_addr); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mov_ori_valid got %b want 1", out_valid); end
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mov_done got %b want 0", out_valid); end
        issue(4'd7, 1'b1, 4'd1, 4'd0, 16'h0080);
        checks++; if (out_word !== 16'hD180 || out_addr !== 8'h07) begin errors++; $display("FAIL movi got %h@%h want d180@07", out_word, out_addr); end
        idle();
    endtask

    task automatic test_err();
        issue(4'd0, 1'b1, 4'd1, 4'd0, 16'h0080);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL addi_range_err got %b want 1", err); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_range_valid got %b want 0", out_valid); end
        checks++; if (out_addr !== 8'h08) begin errors++; $display("FAIL addi_range_addr got %h want 08", out_addr); end
        idle();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pulse_width got %b want 0", err); end
        issue(4'd12, 1'b0, 4'd1, 4'd2, 16'h0);
        checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL illegal_op got err=%b valid=%b want err=1 valid=0", err, out_valid); end
        issue(4'd9, 1'b1, 4'd1, 4'd2, 16'h0001);
        checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL ashui got err=%b valid=%b want err=1 valid=0", err, out_valid); end
        issue(4'd5, 1'b1, 4'd1, 4'd2, 16'h0100);
        checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL andi_range got err=%b valid=%b want err=1 valid=0", err, out_valid); end
        issue(4'd9, 1'b0, 4'd2, 4'd3, 16'h0);
        checks++; if (err !== 1'b0 || out_word !== 16'h8263 || out_addr !== 8'h08) begin errors++; $display("FAIL ashu_reg got err=%b %h@%h want err=0 8263@08", err, out_word, out_addr); end
        idle();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        issue(4'd6, 1'b0, 4'd1, 4'd2, 16'h0);
        for (int i = 0; i < 3; i++) begin
            idle();
            checks++; if (out_word !== 16'h0132 || out_addr !== 8'h09 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] got %h@%h v=%b want 0132@09 v=1", i, out_word, out_addr, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        idle();
        checks++; if (out_valid !== 1'b0 || out_addr !== 8'h0A) begin errors++; $display("FAIL stall_release got v=%b addr=%h want v=0 addr=0a", out_valid, out_addr); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ea;
        logic [15:0] ew;
        logic [3:0]  rd;
        logic [7:0]  iv;
        ea = 8'h0A;
        out_ready = 1'b1;
        for (int i = 0; i < 250; i++) begin
            rd = 4'(i); iv = 8'(i * 3);
            in_op = 4'd7; in_imm_mode = 1'b1; in_rdest = rd; in_rsrc = 4'd0; in_imm = {8'h00, iv}; in_valid = 1'b1;
            ew = {4'hD, rd, iv};
            @(posedge clk); #1;
            checks++; if (out_word !== ew || out_addr !== ea || out_valid !== 1'b1) begin errors++; $display("FAIL b2b[%0d] got %h@%h v=%b want %h@%h v=1", i, out_word, out_addr, out_valid, ew, ea); end
            ea = ea + 8'd1;
        end
        in_valid = 1'b0;
        idle();
        checks++; if (out_valid !== 1'b0 || out_addr !== 8'h04) begin errors++; $display("FAIL b2b_wrap got v=%b addr=%h want v=0 addr=04", out_valid, out_addr); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        issue(4'd7, 1'b1, 4'd5, 4'd0, 16'h3456);
        checks++; if (out_word !== 16'hF534 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_lui got %h rdy=%b want f534 rdy=0", out_word, in_ready); end
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_word !== 16'h0000 || out_addr !== 8'h00) begin errors++; $display("FAIL rst_mid_clear got v=%b %h@%h want v=0 0000@00", out_valid, out_word, out_addr); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_ori got v=%b word=%h want v=0", out_valid, out_word); end
        issue(4'd0, 1'b0, 4'd1, 4'd1, 16'h0);
        checks++; if (out_word !== 16'h0151 || out_addr !== 8'h00) begin errors++; $display("FAIL rst_mid_next got %h@%h want 0151@00", out_word, out_addr); end
        idle();
    endtask

    initial begin
        test_reset();
        test_reg_add();
        test_imm_alu();
        test_mov();
        test_err();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: in_valid  input  1  request holds a valid instruction description.
REQ-004 SHALL: in_ready  output  1  encoder accepts a request this cycle.
REQ-005 SHALL: in_op  input  4  mnemonic: 0 ADD, 1 SUB, 2 MUL, 3 OR, 4 CMP, 5 AND, 6 XOR, 7 MOV, 8 LSH, 9 ASHU; 10-15 illegal.
REQ-006 SHALL: in_imm_mode  input  1  1 = immediate form, 0 = register form.
REQ-007 SHALL: in_rdest, in_rsrc  input  4 each  destination and source register numbers.
REQ-008 SHALL: in_imm  input  16  immediate value, two's complement.
REQ-009 SHALL: out_valid  output  1  out_word is valid.
REQ-010 SHALL: out_ready  input  1  program-memory writer accepts the word.
REQ-011 SHALL: out_word  output  16  encoded instruction word.
REQ-012 SHALL: out_addr  output  8  program-memory address of out_word.
REQ-013 SHALL: err  output  1  one-cycle pulse: the accepted request was unencodable.

Function
REQ-014 SHALL: word layout is [15:12] opcode, [11:8] Rdest, [7:4] op-extension or imm[7:4], [3:0] Rsrc or imm[3:0].
REQ-015 SHALL: register form is opcode 0000 with extension ADD 0101, SUB 1001, MUL 1110, OR 0010, CMP 1011, AND 0001, XOR 0011, MOV 1101; LSH is opcode 1000 with extension 0100, and ASHU is opcode 1000 with extension 0110.
REQ-016 SHALL: immediate form uses the register-form extension as the opcode and carries imm8 in [7:0].
REQ-017 SHALL: ADD, SUB, MUL and CMP immediates are single-word only if in_imm[15:7] are all equal (sign-extended 8-bit); the SUB immediate is emitted uninverted.
REQ-018 SHALL: AND, OR and XOR immediates are single-word only if in_imm[15:8] == 0.
REQ-019 SHALL: MOV immediate with in_imm[15:8] == 0 emits one word, MOVI (opcode 1101).
REQ-020 SHALL: MOV immediate with in_imm[15:8] != 0 emits two words: first LUI {1111, Rd, in_imm[15:8]}, then ORI {0010, Rd, in_imm[7:0]}.
REQ-021 SHALL: LSH immediate emits LSHI {1000, Rd, 0000, in_imm[3:0]} only if in_imm[15:4] == 0.
REQ-022 SHALL: any of the following is unencodable: an illegal in_op, an ASHU immediate, or an out-of-range immediate.
REQ-023 SHALL: for an unencodable request, it is accepted, err pulses on the next cycle, and nothing is emitted.
REQ-024 SHALL: FSM states are IDLE, EMIT_HI (LUI pending acceptance) and EMIT_LAST (final or only word presented).
REQ-025 SHALL: in_ready = (state == IDLE) or (state == EMIT_LAST and out_ready).
REQ-026 SHALL: an accept is in_valid and in_ready at a rising edge; out_valid and the first word appear on the following cycle, giving 1-cycle latency.
REQ-027 SHALL: on accept, the next state is EMIT_HI for a two-word MOV, EMIT_LAST for an encodable single-word request, and IDLE for an unencodable request.
REQ-028 SHALL: EMIT_HI moves to EMIT_LAST when out_ready is high, loading the ORI word.
REQ-029 SHALL: EMIT_LAST moves to IDLE when out_ready is high and no accept occurs.
REQ-030 SHALL: a word is transferred when out_valid and out_ready are both high; while out_ready is low, out_word and out_addr hold stable.
REQ-031 SHALL: an accept coincident with the final-word transfer replaces the word without a bubble, sustaining one word per cycle.
REQ-032 SHALL: out_addr increments by 1 on each transfer and wraps from 255 to 0.
REQ-033 SHALL: the input fields are captured at accept; later changes have no effect.

Reset
REQ-034 SHALL: while reset_n is low, state = IDLE, out_valid = 0, out_word = 0x0000, out_addr = 0x00 and err = 0.
REQ-035 SHALL: a reset during EMIT_HI or EMIT_LAST discards the pending words, and after release the next word is written to address 0.

Verification
REQ-036 SHALL: register ADD with Rd = 3 and Rs = 5 -> out_word 0x0355 at out_addr 0x00 one cycle after accept.
REQ-037 SHALL: ADD immediate -3 (0xFFFD) to R2 -> 0x52FD; SUB immediate 5 to R0 -> 0x9005.
REQ-038 SHALL: MOV immediate 0x12AB to R4 -> 0xF412 at address 0, then 0x24AB at address 1; in_ready is low during EMIT_HI.
REQ-039 SHALL: MOV immediate 0x0080 to R1 -> 0xD180; ADD immediate 0x0080 to R1 -> err pulse, no word, out_addr unchanged.
REQ-040 SHALL: with out_ready held low for 3 cycles, out_word holds; then back-to-back single-word requests with out_ready = 1 give one word per cycle and out_addr wraps 0xFF -> 0x00.
REQ-041 SHALL: reset_n asserted in EMIT_HI -> no ORI word is emitted, and after release the next request lands at address 0.
